// File: rtl/alu_pkg.sv
// Shared constants for the ALU arbiter: opcodes, flag bit positions and sequencer states.
// The legality check is only referenced when ALU_ARBITER_OPCHK_EN is defined.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SLR = 4'b1001;
  localparam logic [3:0] OP_SRL = 4'b1010;
  localparam logic [3:0] OP_SRA = 4'b1011;

  localparam int FLG_S = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SLL, OP_SLR, OP_SRL, OP_SRA: op_legal = 1'b1;
      default:                        op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-input round-robin picker; on a tie the requester not granted last wins.
// START_PRIO selects which requester wins the first tie after reset.
module rr_arb2 #(
  parameter int START_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last <= (START_PRIO == 0) ? 1'b1 : 1'b0;
    else if (|gnt)   last <= gnt[1];
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters with an IDLE/EXEC/RESP sequencer.
// Define ALU_ARBITER_OPCHK_EN to reject illegal opcodes with RSP_ERR instead of issuing them.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DW         = 16,
  parameter int START_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [3:0]    req0_op,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic [3:0]    req1_op,
  output logic          req1_ready,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_s,
  input  logic [DW-1:0] alu_res,
  input  logic [3:0]    alu_flag,
  output logic          rsp_valid,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_data,
  output logic [3:0]    rsp_flag,
  output logic          rsp_err,
  input  logic          rsp_ready,
  output logic [15:0]   op_cnt
);

  state_t        state, state_nxt;
  logic [1:0]    gnt;
  logic          accept, illegal, handshake;
  logic [DW-1:0] a_sel, b_sel;
  logic [3:0]    op_sel;

  // Grants are suppressed while reset is held so READY reads 0 during reset.
  rr_arb2 #(.START_PRIO(START_PRIO)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    ((state == ST_IDLE) && rst_n),
    .req   ({req1_valid, req0_valid}),
    .gnt   (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign accept     = |gnt;
  assign handshake  = rsp_valid && rsp_ready;
  assign a_sel      = gnt[1] ? req1_a  : req0_a;
  assign b_sel      = gnt[1] ? req1_b  : req0_b;
  assign op_sel     = gnt[1] ? req1_op : req0_op;

`ifdef ALU_ARBITER_OPCHK_EN
  assign illegal = !op_legal(op_sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rsp_err <= 1'b0;
    else if (accept) rsp_err <= illegal;
  end
`else
  assign illegal = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = illegal ? ST_RESP : ST_EXEC;
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (handshake) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_s     <= '0;
      rsp_id    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_flag  <= '0;
      op_cnt    <= '0;
    end else begin
      if (accept) begin
        alu_a  <= a_sel;
        alu_b  <= b_sel;
        alu_s  <= op_sel;
        rsp_id <= gnt[1];
        if (illegal) begin
          rsp_valid <= 1'b1;
          rsp_data  <= '0;
          rsp_flag  <= '0;
        end
      end
      if (state == ST_EXEC) begin
        rsp_data  <= alu_res;
        rsp_flag  <= alu_flag;
        rsp_valid <= 1'b1;
      end
      if (handshake) begin
        rsp_valid <= 1'b0;
        op_cnt    <= op_cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one combinational 16-bit ALU between two requesters. Uses a round-robin grant and a 3-state sequencer (IDLE/EXEC/RESP). The block drives the ALU operand and opcode inputs from registers and captures the ALU result and flags. It then returns them on a shared response channel with a valid/ready handshake. It sits between the decode/issue stages and the shared ALU instance.

Parameters:
DW, 16, operand/result width; must match the ALU (16).
START_PRIO, 0, requester favoured on the first contention after reset (0 or 1).

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  asynchronous active-low reset
REQ0_VALID  input  1  requester 0 has an operation
REQ0_A, REQ0_B  input  DW  requester 0 operands
REQ0_OP  input  4  requester 0 opcode
REQ0_READY  output  1  requester 0 operation accepted this cycle
REQ1_VALID, REQ1_A, REQ1_B, REQ1_OP, REQ1_READY  as requester 0
ALU_A, ALU_B  output  DW  to ALU DATA_A/DATA_B
ALU_S  output  4  to ALU S_ALU
ALU_RES  input  DW  from ALU_OUT
ALU_FLAG  input  4  from FLAG_OUT {S,Z,C,V}
RSP_VALID  output  1  response available
RSP_ID  output  1  requester that owns the response
RSP_DATA  output  DW  registered result
RSP_FLAG  output  4  registered {S,Z,C,V}
RSP_ERR  output  1  illegal opcode (optional feature)
RSP_READY  input  1  consumer accepts the response
OP_CNT  output  16  completed-response count, wraps at 0xFFFF->0

Behaviour:
- Reset (RST_N low, asynchronous):
  - State IDLE.
  - All outputs 0: REQx_READY, RSP_*, ALU_A/B/S, OP_CNT.
  - Round-robin pointer set so START_PRIO wins the first tie.
  - Reset during EXEC or RESP discards the in-flight operation; no response is produced.
- IDLE:
  - If any REQx_VALID, the grant goes combinationally to one requester.
  - The single valid requester wins; if both are valid, the requester not last granted wins.
  - REQx_READY=1 for the winner only, in that same cycle.
  - On that edge: latch A, B, OP and the ID into registers; update the last-granted pointer; go to EXEC.
  - If no requester is valid, stay in IDLE.
- EXEC (1 cycle):
  - ALU_A/B/S come from the registers; they are held stable at all times, not only in EXEC.
  - On the edge, capture ALU_RES into RSP_DATA and ALU_FLAG into RSP_FLAG; set RSP_VALID=1; go to RESP.
- RESP:
  - RSP_* held stable while RSP_VALID=1 and RSP_READY=0; no back-pressure timeout.
  - On RSP_VALID and RSP_READY: RSP_VALID goes to 0, OP_CNT increments, state goes to IDLE.
  - No new grant is made in the handshake cycle.
- Handshakes:
  - REQx_READY is never asserted outside IDLE.
  - A requester holds VALID and its operands until READY.
  - Deasserting VALID before READY is legal; the request is simply not taken.
- Timing:
  - Latency: accept at edge T gives RSP_VALID=1 after edge T+1.
  - Minimum issue interval is 3 cycles (IDLE, EXEC, RESP with immediate RSP_READY).
- Width: ALU result and flags pass through unmodified; the block does no arithmetic except the OP_CNT increment (modulo 2^16).
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1 (START_PRIO=0).

Optional Feature:
Macro: ALU_ARBITER_OPCHK_EN.
- Defined:
  - Legal opcodes are 0000, 0001, 0010, 0011, 0100, 1000, 1001, 1010, 1011; any other REQx_OP is illegal.
  - An illegal opcode is still accepted (READY=1) but skips the ALU: IDLE goes directly to RESP.
  - Response for an illegal opcode: RSP_DATA=0, RSP_FLAG=0, RSP_ERR=1. OP_CNT still increments.
- Not defined:
  - All opcodes are issued to the ALU (undefined opcodes return 0 with Z=1).
  - RSP_ERR is tied to 0.

Decomposition:
- Package alu_pkg holds:
  - opcode constants OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SLR, OP_SRL, OP_SRA;
  - flag bit indices FLG_S=3, FLG_Z=2, FLG_C=1, FLG_V=0;
  - state encoding ST_IDLE, ST_EXEC, ST_RESP.
- One sub-module, rr_arb2: two-input round-robin picker with the last-grant register and START_PRIO parameter.

Test Plan:
- Req0 only, ADD 0x7FFF+0x0001, RSP_READY=1 → RSP_VALID after edge T+1, RSP_ID=0, DATA=0x8000, FLAG=1001 (S=1,V=1), OP_CNT=1.
- Both valid every cycle, 4 ops each, START_PRIO=0 → RSP_ID sequence 0,1,0,1,0,1,0,1; no READY during EXEC/RESP.
- RSP_READY held low 5 cycles after SUB 0x0005-0x0005 → RSP_DATA=0x0000 and FLAG=0100 held stable; REQ1_VALID ignored until the handshake completes.
- RST_N pulsed low mid-EXEC → all outputs 0 immediately; next grant goes to START_PRIO; no stale response appears.
- OP=0x5 with ALU_ARBITER_OPCHK_EN → RSP_ERR=1, DATA=0, response 1 cycle after accept. Without the macro → RSP_ERR=0, DATA=0, FLAG=0100.
- OP_CNT preloaded near wrap via 65536 ops (or force) → 0xFFFF then 0x0000.
